// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch path.
// Entry layout is {instr, pc} so the skid buffer can treat it as one vector.
package fetch_pkg;

  localparam int unsigned            DEF_ADDR_W   = 32;
  localparam logic [DEF_ADDR_W-1:0]  DEF_RESET_PC = '0;
  localparam logic [31:0]            NOP_INSTR    = 32'h0;

  typedef struct packed {
    logic [31:0]           instr;
    logic [DEF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO with the head held in a register so the consumer sees flop outputs.
// Push and pop in the same cycle are both honoured; flush empties it and drops any push.
module fetch_skid_buf #(
  parameter int unsigned       DATA_W  = 64,
  parameter logic [DATA_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic              flush_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] tail_q, tail_d;
  logic [1:0]        occ_q, occ_d;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) head_d = din_i;
          else               tail_d = din_i;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          head_d = tail_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          // occupancy is unchanged; the new word goes behind whatever survives the pop
          if (occ_q == 2'd2) begin
            head_d = tail_q;
            tail_d = din_i;
          end else begin
            head_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= RST_VAL;
      tail_q <= RST_VAL;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  assign dout_o = head_q;
  assign occ_o  = occ_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push_i && !pop_i && !flush_i && occ_q == 2'd2));

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer for a 1-cycle synchronous instruction ROM: owns the PC, tags returns
// with their address, buffers them two deep and squashes wrong-path words on redirect.
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
  parameter int unsigned       PC_STEP  = 1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] pc;
  } entry_t;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] inflight_pc_q, inflight_pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        occ;
  logic [2:0]        committed;
  logic              pop, push, issue;
  entry_t            push_dat, head_dat;

  assign out_valid = (occ != 2'd0);
  assign pop       = out_valid && out_ready;
  // Slots already spoken for after this edge; issuing only below 2 keeps the buffer from overflowing.
  assign committed = {1'b0, occ} + {2'b0, inflight_q} - {2'b0, pop};
  assign issue     = !rst && !halt && !redirect_valid && (committed < 3'd2);

  assign rom_en    = issue;
  assign rom_addr  = fetch_pc_q;

  assign push           = inflight_q && !redirect_valid;
  assign push_dat.instr = rom_instr;
  assign push_dat.pc    = inflight_pc_q;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
    end else if (issue) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(PC_STEP);
      inflight_pc_d = fetch_pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
    end
  end

  fetch_skid_buf #(
    .DATA_W  ($bits(entry_t)),
    .RST_VAL ({NOP_INSTR, {ADDR_W{1'b0}}})
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .din_i   (push_dat),
    .dout_o  (head_dat),
    .occ_o   (occ)
  );

  assign out_instr = head_dat.instr;
  assign out_pc    = head_dat.pc;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: a 32-bit instance for streaming/stall/redirect/halt/reset
// and a 4-bit instance starting at 15 for PC wrap, each with its own ROM and scoreboard.
module tb_instr_fetch_ctrl;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        rst, halt, redirect_valid, out_ready;
  logic [31:0] redirect_pc;
  logic        rom_en, out_valid;
  logic [31:0] rom_addr, rom_instr, out_instr, out_pc;

  // 4-bit wrap instance
  logic        rst_b, halt_b, redirect_valid_b, out_ready_b;
  logic [3:0]  redirect_pc_b;
  logic        rom_en_b, out_valid_b;
  logic [3:0]  rom_addr_b, out_pc_b;
  logic [31:0] rom_instr_b, out_instr_b;

  int   errors = 0;
  int   checks = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;

  instr_fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0), .PC_STEP(1)) dut_a (
    .clk(clk), .rst(rst), .rom_en(rom_en), .rom_addr(rom_addr), .rom_instr(rom_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch_ctrl #(.ADDR_W(4), .RESET_PC(4'hF), .PC_STEP(1)) dut_b (
    .clk(clk), .rst(rst_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_instr(rom_instr_b),
    .redirect_valid(redirect_valid_b), .redirect_pc(redirect_pc_b), .halt(halt_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_instr(out_instr_b), .out_pc(out_pc_b)
  );

  // Synchronous ROMs: word[i] = A000_0000 + i, one cycle after the read
  always @(posedge clk) if (rom_en)   rom_instr   <= 32'hA000_0000 + rom_addr;
  always @(posedge clk) if (rom_en_b) rom_instr_b <= 32'hA000_0000 + {28'h0, rom_addr_b};

  // Monitors: every handshake pops one expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (q_a.size() == 0) begin
        errors++;
        $display("FAIL accept_a: unexpected word instr=%h pc=%h", out_instr, out_pc);
      end else begin
        ea = q_a.pop_front();
        if (out_instr !== ea.instr || out_pc !== ea.pc) begin
          errors++;
          $display("FAIL accept_a: got instr=%h pc=%h want instr=%h pc=%h",
                   out_instr, out_pc, ea.instr, ea.pc);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst_b && out_valid_b && out_ready_b) begin
      checks++;
      if (q_b.size() == 0) begin
        errors++;
        $display("FAIL accept_b: unexpected word instr=%h pc=%h", out_instr_b, out_pc_b);
      end else begin
        eb = q_b.pop_front();
        if (out_instr_b !== eb.instr || {28'h0, out_pc_b} !== eb.pc) begin
          errors++;
          $display("FAIL accept_b: got instr=%h pc=%h want instr=%h pc=%h",
                   out_instr_b, out_pc_b, eb.instr, eb.pc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  task automatic push_a(input int first, input int n);
    for (int i = 0; i < n; i++) q_a.push_back({32'hA000_0000 + 32'(first + i), 32'(first + i)});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; halt = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    rst_b = 1'b1; halt_b = 1'b0; redirect_valid_b = 1'b0; redirect_pc_b = '0; out_ready_b = 1'b0;
    push_a(0, 13);
    q_b.push_back({32'hA000_000F, 32'd15});
    q_b.push_back({32'hA000_0000, 32'd0});
    q_b.push_back({32'hA000_0001, 32'd1});

    repeat (2) tick();
    #2;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_rom_en", {31'h0, rom_en}, 32'h0);
    chk("rst_rom_addr", rom_addr, 32'h0);
    chk("rst_rom_addr_b", {28'h0, rom_addr_b}, 32'hF);

    tick();  // cycle 0: first issue
    rst = 1'b0; rst_b = 1'b0; out_ready = 1'b1; out_ready_b = 1'b1;
    #2;
    chk("c0_rom_en", {31'h0, rom_en}, 32'h1);
    chk("c0_rom_addr", rom_addr, 32'h0);
    chk("c0_rom_addr_b", {28'h0, rom_addr_b}, 32'hF);
    tick();  // cycle 1
    #2;
    chk("c1_rom_addr", rom_addr, 32'h1);
    chk("c1_rom_addr_b_wrap", {28'h0, rom_addr_b}, 32'h0);
    chk("c1_out_valid", {31'h0, out_valid}, 32'h0);
    tick();  // cycle 2: first word visible
    #2;
    chk("c2_out_valid", {31'h0, out_valid}, 32'h1);
    repeat (3) tick();  // cycle 5
    out_ready_b = 1'b0;

    repeat (5) tick();  // cycle 10: decode stalls for 5 cycles
    out_ready = 1'b0;
    #2;
    chk("stall_rom_en", {31'h0, rom_en}, 32'h0);
    chk("stall_out_pc", out_pc, 32'h8);
    for (int i = 0; i < 4; i++) begin
      tick();
      #2;
      chk("stall_hold_rom_en", {31'h0, rom_en}, 32'h0);
      chk("stall_hold_out_pc", out_pc, 32'h8);
      chk("stall_hold_out_instr", out_instr, 32'hA000_0008);
    end
    tick();  // cycle 15
    out_ready = 1'b1;

    repeat (5) tick();  // cycle 20
    out_ready = 1'b0;
    tick();
    tick();  // cycle 22: buffer full, redirect to 0x40
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    push_a(32'h40, 12);
    #2;
    chk("redir_rom_en", {31'h0, rom_en}, 32'h0);
    tick();  // cycle 23
    redirect_valid = 1'b0; out_ready = 1'b1;
    #2;
    chk("post_redir_out_valid", {31'h0, out_valid}, 32'h0);
    chk("post_redir_rom_en", {31'h0, rom_en}, 32'h1);
    chk("post_redir_rom_addr", rom_addr, 32'h40);

    repeat (7) tick();  // cycle 30: halt for 4 cycles
    halt = 1'b1;
    #2;
    chk("halt_rom_en", {31'h0, rom_en}, 32'h0);
    tick();
    tick();  // cycle 32: inflight word delivered, buffer drained
    #2;
    chk("halt_drained_out_valid", {31'h0, out_valid}, 32'h0);
    chk("halt_drained_rom_en", {31'h0, rom_en}, 32'h0);
    tick();
    tick();  // cycle 34
    halt = 1'b0;
    #2;
    chk("resume_rom_en", {31'h0, rom_en}, 32'h1);
    chk("resume_rom_addr", rom_addr, 32'h47);

    repeat (7) tick();  // cycle 41
    out_ready = 1'b0;
    tick();
    tick();  // cycle 43: reset pulse with a full buffer
    rst = 1'b1;
    push_a(0, 5);
    #2;
    chk("midrst_rom_en", {31'h0, rom_en}, 32'h0);
    tick();  // cycle 44
    rst = 1'b0; out_ready = 1'b1;
    #2;
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_rom_en", {31'h0, rom_en}, 32'h1);
    chk("midrst_rom_addr", rom_addr, 32'h0);

    repeat (7) tick();  // cycle 51
    out_ready = 1'b0;
    repeat (3) tick();
    chk("q_a_drained", 32'(q_a.size()), 32'h0);
    chk("q_b_drained", 32'(q_b.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
